// File: rtl/gray_pixel_packer.sv
// Packs 8-bit grayscale pixels into little-endian 32-bit words and queues them in a FWFT FIFO.
// Optional GRAY_PACKER_STATS_EN adds pixelCount/dropCount statistics outputs.
module gray_pixel_packer #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          frameStart,
  input  logic                          lineEnd,
  input  logic                          pixelValid,
  input  logic [7:0]                    grayscale,
  output logic                          wordValid,
  output logic [31:0]                   wordData,
  output logic                          wordFirst,
  input  logic                          wordReady,
  output logic [$clog2(FIFO_DEPTH):0]   fifoLevel,
  output logic                          overflow,
  input  logic                          clearOverflow
`ifdef GRAY_PACKER_STATS_EN
  ,
  output logic [31:0]                   pixelCount,
  output logic [15:0]                   dropCount
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Packer state
  logic [1:0]  lane_reg;
  logic [23:0] held_reg;
  logic        first_pending_reg;

  // FIFO state
  logic [32:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;
  logic [32:0]      head_reg;
  logic             valid_reg;
  logic             overflow_reg;

  // frameStart takes effect before the same-cycle pixel and lineEnd.
  logic [1:0]  base_lane;
  logic [23:0] base_held;
  logic        base_first;
  logic [31:0] push_data;
  logic        full_push;
  logic        flush_push;
  logic        push_req;
  logic        pop;
  logic        fifo_full;
  logic        push_ok;
  logic        drop;
  logic [1:0]  lane_next;
  logic [23:0] held_next;
  logic        first_pending_next;
  logic [LVL_W-1:0] level_next;
  logic [PTR_W-1:0] rd_ptr_plus1;

  assign base_lane  = frameStart ? 2'd0 : lane_reg;
  assign base_held  = frameStart ? 24'd0 : held_reg;
  assign base_first = frameStart | first_pending_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      if (gi < 3) begin : g_held
        assign push_data[8*gi +: 8] = (pixelValid && (base_lane == 2'(gi)))
                                      ? grayscale : base_held[8*gi +: 8];
      end else begin : g_top
        assign push_data[8*gi +: 8] = (pixelValid && (base_lane == 2'(gi)))
                                      ? grayscale : 8'd0;
      end
    end
  endgenerate

  assign full_push  = pixelValid && (base_lane == 2'd3);
  assign flush_push = lineEnd && ((base_lane != 2'd0) || pixelValid);
  assign push_req   = full_push || flush_push;

  assign pop       = valid_reg && wordReady;
  assign fifo_full = (level_reg == LVL_W'(FIFO_DEPTH));
  assign push_ok   = push_req && (!fifo_full || pop);
  assign drop      = push_req && !push_ok;

  always_comb begin
    lane_next = base_lane;
    held_next = base_held;
    if (push_req) begin
      lane_next = 2'd0;
      held_next = 24'd0;
    end else if (pixelValid) begin
      lane_next = base_lane + 2'd1;
      held_next = push_data[23:0];
    end
  end

  // A dropped first-of-frame word leaves the tag pending for the next word.
  assign first_pending_next = push_ok ? 1'b0 : base_first;

  always_comb begin
    level_next = level_reg;
    if (push_ok && !pop)
      level_next = level_reg + LVL_W'(1);
    else if (pop && !push_ok)
      level_next = level_reg - LVL_W'(1);
  end

  assign rd_ptr_plus1 = rd_ptr_reg + PTR_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      lane_reg          <= 2'd0;
      held_reg          <= 24'd0;
      first_pending_reg <= 1'b1;
    end else begin
      lane_reg          <= lane_next;
      held_reg          <= held_next;
      first_pending_reg <= first_pending_next;
    end
  end

  // Storage array kept reset-free so it maps onto block RAM.
  always_ff @(posedge clock) begin
    if (!reset && push_ok)
      mem[wr_ptr_reg] <= {base_first, push_data};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      valid_reg    <= 1'b0;
      head_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_plus1;
      level_reg <= level_next;
      valid_reg <= (level_next != '0);
      // Head bypasses the array when the pushed word becomes the new head.
      if (push_ok && ((level_reg == '0) || (pop && (level_reg == LVL_W'(1)))))
        head_reg <= {base_first, push_data};
      else if (pop && (level_reg > LVL_W'(1)))
        head_reg <= mem[rd_ptr_plus1];
      if (drop)
        overflow_reg <= 1'b1;
      else if (clearOverflow)
        overflow_reg <= 1'b0;
    end
  end

  assign wordValid = valid_reg;
  assign wordData  = head_reg[31:0];
  assign wordFirst = head_reg[32];
  assign fifoLevel = level_reg;
  assign overflow  = overflow_reg;

`ifdef GRAY_PACKER_STATS_EN
  logic [31:0] pixel_count_reg;
  logic [15:0] drop_count_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      pixel_count_reg <= 32'd0;
      drop_count_reg  <= 16'd0;
    end else begin
      if (frameStart)
        pixel_count_reg <= {31'd0, pixelValid};
      else if (pixelValid)
        pixel_count_reg <= pixel_count_reg + 32'd1;
      if (drop && (drop_count_reg != 16'hFFFF))
        drop_count_reg <= drop_count_reg + 16'd1;
    end
  end

  assign pixelCount = pixel_count_reg;
  assign dropCount  = drop_count_reg;
`endif

endmodule

// File: tb/tb_gray_pixel_packer.sv
// Self-checking bench for gray_pixel_packer: directed scenarios plus randomized traffic
// compared against a byte-queue / word-queue reference model.
module tb_gray_pixel_packer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        fs, le, pv, rdy, clr;
  logic [7:0]  px;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_first;
  logic [$clog2(DEPTH):0] fifo_level;
  logic        ovf;
`ifdef GRAY_PACKER_STATS_EN
  logic [31:0] pixel_count;
  logic [15:0] drop_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [32:0] mq[$];
  logic [7:0]  pend[$];
  bit          m_first;
  bit          m_ovf;
  int unsigned m_drop;
  int unsigned m_pix;

  always #5 clk = ~clk;

  gray_pixel_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .clock(clk),
    .reset(rst),
    .frameStart(fs),
    .lineEnd(le),
    .pixelValid(pv),
    .grayscale(px),
    .wordValid(word_valid),
    .wordData(word_data),
    .wordFirst(word_first),
    .wordReady(rdy),
    .fifoLevel(fifo_level),
    .overflow(ovf),
    .clearOverflow(clr)
`ifdef GRAY_PACKER_STATS_EN
    ,
    .pixelCount(pixel_count),
    .dropCount(drop_count)
`endif
  );

  task automatic model_reset();
    mq.delete();
    pend.delete();
    m_first = 1'b1;
    m_ovf   = 1'b0;
    m_drop  = 0;
    m_pix   = 0;
  endtask

  task automatic model_edge(input bit f, input bit l, input bit p, input bit [7:0] x,
                            input bit r, input bit c);
    bit have_push, dropped, popped;
    logic [32:0] w;
    popped = (mq.size() != 0) && r;
    if (f) begin
      pend.delete();
      m_first = 1'b1;
      m_pix   = 0;
    end
    if (p) begin
      pend.push_back(x);
      m_pix++;
    end
    have_push = (pend.size() == 4) || (l && pend.size() != 0);
    w = '0;
    if (have_push) begin
      foreach (pend[k]) w[8*k +: 8] = pend[k];
      w[32] = m_first;
      pend.delete();
    end
    if (popped) void'(mq.pop_front());
    dropped = 1'b0;
    if (have_push) begin
      if (mq.size() < DEPTH) begin
        mq.push_back(w);
        m_first = 1'b0;
      end else begin
        dropped = 1'b1;
        m_ovf   = 1'b1;
        if (m_drop < 65535) m_drop++;
      end
    end
    if (c && !dropped) m_ovf = 1'b0;
  endtask

  // One clock cycle: drive inputs, advance the model on the edge, return on the falling edge.
  task automatic step(input bit f, input bit l, input bit p, input bit [7:0] x,
                      input bit r, input bit c);
    fs = f; le = l; pv = p; px = x; rdy = r; clr = c;
    @(posedge clk);
    model_edge(f, l, p, x, r, c);
    @(negedge clk);
  endtask

  // Reset with random noise on the data-path inputs, which must be ignored.
  task automatic do_reset();
    rst = 1'b1;
    fs = 1'($urandom); le = 1'($urandom); pv = 1'($urandom);
    px = 8'($urandom); rdy = 1'($urandom); clr = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (word_valid !== 1'b0 || word_data !== 32'd0 || word_first !== 1'b0 ||
        fifo_level !== '0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b data=%h first=%b level=%0d ovf=%b, required 0/00000000/0/0/0",
               word_valid, word_data, word_first, fifo_level, ovf);
    end
`ifdef GRAY_PACKER_STATS_EN
    n_checks++;
    if (pixel_count !== 32'd0 || drop_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_stats: pixelCount=%0d dropCount=%0d, required 0/0", pixel_count, drop_count);
    end
`endif
    $display("test_reset done");
  endtask

  task automatic test_basic_packing();
    do_reset();
    step(1, 0, 1, 8'h11, 1, 0);
    step(0, 0, 1, 8'h22, 1, 0);
    step(0, 0, 1, 8'h33, 1, 0);
    n_checks++;
    if (word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early_valid: valid=%b, required 0", word_valid);
    end
    step(0, 0, 1, 8'h44, 1, 0);
    n_checks++;
    if (word_valid !== 1'b1 || word_data !== 32'h44332211 || word_first !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_word: valid=%b data=%h first=%b, required 1/44332211/1",
               word_valid, word_data, word_first);
    end
    step(0, 0, 0, 8'h00, 1, 0);
    n_checks++;
    if (word_valid !== 1'b0 || fifo_level !== '0) begin
      n_fail++;
      $display("FAIL basic_one_cycle: valid=%b level=%0d, required 0/0", word_valid, fifo_level);
    end
    $display("test_basic_packing done");
  endtask

  task automatic test_line_end_flush();
    step(0, 0, 1, 8'hA1, 1, 0);
    step(0, 0, 1, 8'hB2, 1, 0);
    step(0, 1, 0, 8'h00, 1, 0);
    n_checks++;
    if (word_valid !== 1'b1 || word_data !== 32'h0000B2A1 || word_first !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_partial: valid=%b data=%h first=%b, required 1/0000b2a1/0",
               word_valid, word_data, word_first);
    end
    step(0, 1, 1, 8'hC3, 1, 0);
    n_checks++;
    if (word_valid !== 1'b1 || word_data !== 32'h000000C3 || word_first !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_same_cycle: valid=%b data=%h first=%b, required 1/000000c3/0",
               word_valid, word_data, word_first);
    end
    step(0, 1, 0, 8'h00, 1, 0);
    n_checks++;
    if (word_valid !== 1'b0 || fifo_level !== '0) begin
      n_fail++;
      $display("FAIL flush_empty_lane: valid=%b level=%0d, required 0/0", word_valid, fifo_level);
    end
    $display("test_line_end_flush done");
  endtask

  task automatic test_overflow();
    logic [7:0]  pix [20];
    logic [31:0] exp_w;
    do_reset();
    foreach (pix[i]) pix[i] = 8'($urandom);
    for (int i = 0; i < 20; i++) step(i == 0, 0, 1, pix[i], 0, 0);
    n_checks++;
    if (fifo_level !== 3'(DEPTH) || ovf !== 1'b1 || word_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_state: level=%0d ovf=%b valid=%b, required 4/1/1", fifo_level, ovf, word_valid);
    end
`ifdef GRAY_PACKER_STATS_EN
    n_checks++;
    if (drop_count !== 16'd1 || pixel_count !== 32'd20) begin
      n_fail++;
      $display("FAIL ovf_stats: dropCount=%0d pixelCount=%0d, required 1/20", drop_count, pixel_count);
    end
`endif
    step(0, 0, 0, 8'h00, 0, 1);
    n_checks++;
    if (ovf !== 1'b0 || fifo_level !== 3'(DEPTH)) begin
      n_fail++;
      $display("FAIL ovf_clear: ovf=%b level=%0d, required 0/4", ovf, fifo_level);
    end
    for (int k = 0; k < 4; k++) begin
      exp_w = {pix[4*k+3], pix[4*k+2], pix[4*k+1], pix[4*k]};
      n_checks++;
      if (word_valid !== 1'b1 || word_data !== exp_w || word_first !== (k == 0)) begin
        n_fail++;
        $display("FAIL ovf_order[%0d]: valid=%b data=%h first=%b, required 1/%h/%b",
                 k, word_valid, word_data, word_first, exp_w, k == 0);
      end
      step(0, 0, 0, 8'h00, 1, 0);
    end
    n_checks++;
    if (word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_drained: valid=%b, required 0", word_valid);
    end
    $display("test_overflow done");
  endtask

  task automatic test_full_same_cycle_pop();
    logic [7:0]  pix [20];
    logic [31:0] exp_w;
    do_reset();
    foreach (pix[i]) pix[i] = 8'($urandom);
    for (int i = 0; i < 19; i++) step(i == 0, 0, 1, pix[i], 0, 0);
    step(0, 0, 1, pix[19], 1, 0);
    n_checks++;
    if (fifo_level !== 3'(DEPTH) || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pop_state: level=%0d ovf=%b, required 4/0", fifo_level, ovf);
    end
    for (int k = 1; k < 5; k++) begin
      exp_w = {pix[4*k+3], pix[4*k+2], pix[4*k+1], pix[4*k]};
      n_checks++;
      if (word_valid !== 1'b1 || word_data !== exp_w || word_first !== 1'b0) begin
        n_fail++;
        $display("FAIL full_pop_order[%0d]: valid=%b data=%h first=%b, required 1/%h/0",
                 k, word_valid, word_data, word_first, exp_w);
      end
      step(0, 0, 0, 8'h00, 1, 0);
    end
    $display("test_full_same_cycle_pop done");
  endtask

  task automatic test_frame_start_mid_word();
    do_reset();
    step(0, 0, 1, 8'h01, 1, 0);
    step(0, 0, 1, 8'h02, 1, 0);
    step(1, 0, 1, 8'h05, 1, 0);
    step(0, 0, 1, 8'h06, 1, 0);
    step(0, 0, 1, 8'h07, 1, 0);
    n_checks++;
    if (word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fs_no_early_word: valid=%b, required 0", word_valid);
    end
    step(0, 0, 1, 8'h08, 1, 0);
    n_checks++;
    if (word_valid !== 1'b1 || word_data !== 32'h08070605 || word_first !== 1'b1 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL fs_word: valid=%b data=%h first=%b ovf=%b, required 1/08070605/1/0",
               word_valid, word_data, word_first, ovf);
    end
    step(0, 1, 0, 8'h00, 1, 0);
    n_checks++;
    if (word_valid !== 1'b0 || fifo_level !== '0) begin
      n_fail++;
      $display("FAIL fs_single_word: valid=%b level=%0d, required 0/0", word_valid, fifo_level);
    end
    $display("test_frame_start_mid_word done");
  endtask

  task automatic test_reset_mid_operation();
    do_reset();
    for (int i = 0; i < 14; i++) step(i == 0, 0, 1, 8'(i + 1), 0, 0);
    n_checks++;
    if (fifo_level !== 3'd3) begin
      n_fail++;
      $display("FAIL rst_mid_prefill: level=%0d, required 3", fifo_level);
    end
    do_reset();
    n_checks++;
    if (fifo_level !== '0 || word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_cleared: level=%0d valid=%b, required 0/0", fifo_level, word_valid);
    end
    step(0, 0, 1, 8'hD0, 0, 0);
    step(0, 0, 1, 8'hD1, 0, 0);
    step(0, 0, 1, 8'hD2, 0, 0);
    step(0, 0, 1, 8'hD3, 0, 0);
    n_checks++;
    if (word_valid !== 1'b1 || word_data !== 32'hD3D2D1D0 || word_first !== 1'b1 || fifo_level !== 3'd1) begin
      n_fail++;
      $display("FAIL rst_mid_next_word: valid=%b data=%h first=%b level=%0d, required 1/d3d2d1d0/1/1",
               word_valid, word_data, word_first, fifo_level);
    end
    $display("test_reset_mid_operation done");
  endtask

  task automatic test_random();
    int errs_before;
    errs_before = n_fail;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else step($urandom_range(0, 40) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 3) != 0, 8'($urandom),
                $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
      n_checks++;
      if (word_valid !== (mq.size() != 0) || int'(fifo_level) !== mq.size() || ovf !== m_ovf) begin
        n_fail++;
        $display("FAIL rand_state@%0d: valid=%b level=%0d ovf=%b, required %b/%0d/%b",
                 cyc, word_valid, fifo_level, ovf, mq.size() != 0, mq.size(), m_ovf);
      end
      if (mq.size() != 0) begin
        n_checks++;
        if (word_data !== mq[0][31:0] || word_first !== mq[0][32]) begin
          n_fail++;
          $display("FAIL rand_head@%0d: data=%h first=%b, required %h/%b",
                   cyc, word_data, word_first, mq[0][31:0], mq[0][32]);
        end
      end
`ifdef GRAY_PACKER_STATS_EN
      n_checks++;
      if (pixel_count !== m_pix || drop_count !== 16'(m_drop)) begin
        n_fail++;
        $display("FAIL rand_stats@%0d: pixelCount=%0d dropCount=%0d, required %0d/%0d",
                 cyc, pixel_count, drop_count, m_pix, m_drop);
      end
`endif
    end
    $display("test_random done, %0d new failures", n_fail - errs_before);
  endtask

  initial begin
    rst = 1'b1; fs = 1'b0; le = 1'b0; pv = 1'b0; px = 8'h00; rdy = 1'b0; clr = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic_packing();
    test_line_end_flush();
    test_overflow();
    test_full_same_cycle_pop();
    test_frame_start_mid_word();
    test_reset_mid_operation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
